// File: rtl/verifier_horner_pkg.sv
// Shared definitions for the runtime-degree Horner evaluator: field constants, FSM states,
// and the coefficient-index width helper.
package verifier_horner_pkg;

  localparam int unsigned F_NBITS = 61;
  // Field modulus p = 2^61 - 1
  localparam logic [F_NBITS-1:0] F_I = 61'h1FFF_FFFF_FFFF_FFFF;

  localparam int unsigned FAILIDX_XBITS = 4;

  typedef enum logic [2:0] {IDLE, STEP, ACC, RDBL, DONE} state_e;

  function automatic int unsigned calc_cbits(input int unsigned max_deg);
    return (max_deg < 1) ? 1 : $clog2(max_deg + 1);
  endfunction

endpackage

// File: rtl/field_adder.sv
// Modular adder over F_I with an en/ready handshake; result is valid when ready returns high.
module field_adder
  import verifier_horner_pkg::*;
(
  input  logic               clk,
  input  logic               rstb,
  input  logic               en,
  input  logic [F_NBITS-1:0] a,
  input  logic [F_NBITS-1:0] b,
  output logic [F_NBITS-1:0] res,
  output logic               ready
);
  logic               busy_q;
  logic [F_NBITS-1:0] a_q, b_q, red;
  logic [F_NBITS:0]   sum;

  always_comb begin
    sum = {1'b0, a_q} + {1'b0, b_q};
    red = (sum >= {1'b0, F_I}) ? F_NBITS'(sum - {1'b0, F_I}) : sum[F_NBITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      busy_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      res    <= '0;
    end else if (busy_q) begin
      busy_q <= 1'b0;
      res    <= red;
    end else if (en) begin
      busy_q <= 1'b1;
      a_q    <= a;
      b_q    <= b;
    end
  end

  assign ready = ~busy_q & ~en;

endmodule

// File: rtl/field_multiplier.sv
// Modular multiplier over the Mersenne prime F_I with an en/ready handshake.
module field_multiplier
  import verifier_horner_pkg::*;
(
  input  logic               clk,
  input  logic               rstb,
  input  logic               en,
  input  logic [F_NBITS-1:0] a,
  input  logic [F_NBITS-1:0] b,
  output logic [F_NBITS-1:0] res,
  output logic               ready
);
  logic                 busy_q;
  logic [F_NBITS-1:0]   a_q, b_q, red;
  logic [2*F_NBITS-1:0] prod;
  logic [F_NBITS:0]     s1, s2;

  // 2^61 == 1 mod p, so the high half folds onto the low half.
  always_comb begin
    prod = {{F_NBITS{1'b0}}, a_q} * {{F_NBITS{1'b0}}, b_q};
    s1   = {1'b0, prod[F_NBITS-1:0]} + {1'b0, prod[2*F_NBITS-1:F_NBITS]};
    s2   = {1'b0, s1[F_NBITS-1:0]} + {{F_NBITS{1'b0}}, s1[F_NBITS]};
    red  = (s2 >= {1'b0, F_I}) ? F_NBITS'(s2 - {1'b0, F_I}) : s2[F_NBITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      busy_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      res    <= '0;
    end else if (busy_q) begin
      busy_q <= 1'b0;
      res    <= red;
    end else if (en) begin
      busy_q <= 1'b1;
      a_q    <= a;
      b_q    <= b;
    end
  end

  assign ready = ~busy_q & ~en;

endmodule

// File: rtl/verifier_horner_coeff_mux.sv
// Selects c[idx] and c[idx-1] from the flat coefficient bus; indices clamp into 0..maxDegree.
module verifier_horner_coeff_mux
  import verifier_horner_pkg::*;
#(
  parameter int unsigned maxDegree = 8,
  parameter int unsigned cBits     = calc_cbits(maxDegree)
) (
  input  logic [F_NBITS*(maxDegree+1)-1:0] c_in,
  input  logic [cBits-1:0]                 idx,
  output logic [F_NBITS-1:0]               c_hi,
  output logic [F_NBITS-1:0]               c_lo
);
  localparam logic [cBits-1:0] MaxD = cBits'(maxDegree);

  logic [F_NBITS-1:0] coef [maxDegree+1];
  logic [cBits-1:0]   hi_idx, lo_idx;

  for (genvar i = 0; i <= maxDegree; i++) begin : g_coef
    assign coef[i] = c_in[i*F_NBITS +: F_NBITS];
  end

  always_comb begin
    hi_idx = (idx > MaxD) ? MaxD : idx;
    lo_idx = (hi_idx == '0) ? '0 : hi_idx - cBits'(1);
    c_hi   = coef[hi_idx];
    c_lo   = coef[lo_idx];
  end

endmodule

// File: rtl/verifier_compute_horner_gen.sv
// Runtime-degree Horner evaluator (round check + f(tau), or layer sum + H(tau)).
// Optional failing-round index port: VERIFIER_HORNER_FAILIDX_EN.
module verifier_compute_horner_gen
  import verifier_horner_pkg::*;
#(
  parameter int unsigned maxDegree = 8,
  parameter int unsigned cBits     = calc_cbits(maxDegree)
) (
  input  logic                             clk,
  input  logic                             rstb,
  input  logic                             en,
  input  logic                             restart,
  input  logic                             round,
  input  logic                             next_lay,
  input  logic [cBits-1:0]                 degree,
  input  logic [F_NBITS-1:0]               tau,
  input  logic [F_NBITS*(maxDegree+1)-1:0] c_in,
  input  logic [F_NBITS-1:0]               val_in,
  output logic [F_NBITS-1:0]               val_out,
  output logic                             ok,
  output logic [F_NBITS-1:0]               lay_out,
  output logic [F_NBITS-1:0]               v2_out,
  output logic                             ready
`ifdef VERIFIER_HORNER_FAILIDX_EN
  ,
  output logic [cBits+FAILIDX_XBITS-1:0]   fail_round
`endif
);
  if (cBits != calc_cbits(maxDegree)) begin : g_bad_cbits
    $error("cBits is derived from maxDegree and must not be overridden");
  end

  localparam logic [cBits-1:0] MaxD = cBits'(maxDegree);

  state_e             state_q, state_d;
  logic [F_NBITS-1:0] acc_q, acc_d, sum_q, sum_d, val_q, val_d;
  logic [F_NBITS-1:0] lay_q, lay_d, v2_q, v2_d;
  logic [cBits-1:0]   k_q, k_d, d_clamp, mux_idx;
  logic               ok_q, ok_d, issued_q, issued_d, round_q, round_d, en_dly_q, start;
  logic               mul_en, add_en, mul_ready, add_ready;
  logic [F_NBITS-1:0] add_a, add_b, add_res, mul_res, c_hi, c_lo;

  assign start   = en & ~en_dly_q;
  assign d_clamp = (degree > MaxD) ? MaxD : degree;
  assign mux_idx = (state_q == IDLE) ? d_clamp : k_q;

  verifier_horner_coeff_mux #(.maxDegree(maxDegree), .cBits(cBits)) u_mux (
    .c_in (c_in),
    .idx  (mux_idx),
    .c_hi (c_hi),
    .c_lo (c_lo)
  );

  field_multiplier u_mul (
    .clk   (clk),
    .rstb  (rstb),
    .en    (mul_en),
    .a     (acc_q),
    .b     (tau),
    .res   (mul_res),
    .ready (mul_ready)
  );

  field_adder u_add (
    .clk   (clk),
    .rstb  (rstb),
    .en    (add_en),
    .a     (add_a),
    .b     (add_b),
    .res   (add_res),
    .ready (add_ready)
  );

  // issued_q marks that the current state's unit request is in flight.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    sum_d    = sum_q;
    val_d    = val_q;
    lay_d    = lay_q;
    v2_d     = v2_q;
    k_d      = k_q;
    ok_d     = ok_q;
    issued_d = issued_q;
    round_d  = round_q;
    mul_en   = 1'b0;
    add_en   = 1'b0;
    add_a    = sum_q;
    add_b    = c_lo;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          round_d  = round;
          k_d      = d_clamp;
          acc_d    = c_hi;
          sum_d    = c_hi;
          issued_d = 1'b0;
          if (restart) begin
            val_d = val_in;
            ok_d  = 1'b1;
          end
          if (round && next_lay) val_d = lay_q;
          if (d_clamp != '0) state_d = STEP;
          else               state_d = round ? RDBL : DONE;
        end
      end
      STEP: begin
        if (!issued_q) begin
          mul_en   = 1'b1;
          add_en   = 1'b1;
          issued_d = 1'b1;
        end else if (mul_ready && add_ready) begin
          sum_d    = add_res;
          k_d      = k_q - cBits'(1);
          issued_d = 1'b0;
          state_d  = ACC;
        end
      end
      ACC: begin
        add_a = mul_res;
        add_b = c_hi;
        if (!issued_q) begin
          add_en   = 1'b1;
          issued_d = 1'b1;
        end else if (add_ready) begin
          acc_d    = add_res;
          issued_d = 1'b0;
          if (k_q == '0) state_d = round_q ? RDBL : DONE;
          else           state_d = STEP;
        end
      end
      RDBL: begin
        add_b = c_hi;
        if (!issued_q) begin
          add_en   = 1'b1;
          issued_d = 1'b1;
        end else if (add_ready) begin
          sum_d    = add_res;
          issued_d = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        v2_d    = sum_q;
        state_d = IDLE;
        if (round_q) begin
          if (sum_q != val_q) ok_d = 1'b0;
          val_d = acc_q;
        end else begin
          lay_d = acc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      sum_q    <= '0;
      val_q    <= '0;
      lay_q    <= '0;
      v2_q     <= '0;
      k_q      <= '0;
      ok_q     <= 1'b0;
      issued_q <= 1'b0;
      round_q  <= 1'b0;
      en_dly_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      sum_q    <= sum_d;
      val_q    <= val_d;
      lay_q    <= lay_d;
      v2_q     <= v2_d;
      k_q      <= k_d;
      ok_q     <= ok_d;
      issued_q <= issued_d;
      round_q  <= round_d;
      en_dly_q <= en;
    end
  end

`ifdef VERIFIER_HORNER_FAILIDX_EN
  localparam int unsigned FW = cBits + FAILIDX_XBITS;

  logic [FW-1:0] cnt_q, cnt_d, fail_q, fail_d;
  logic          seen_q, seen_d;

  always_comb begin
    cnt_d  = cnt_q;
    fail_d = fail_q;
    seen_d = seen_q;
    if (state_q == IDLE && start && restart) begin
      cnt_d  = '0;
      fail_d = '1;
      seen_d = 1'b0;
    end else if (state_q == DONE && round_q) begin
      if (sum_q != val_q && !seen_q) begin
        fail_d = cnt_q;
        seen_d = 1'b1;
      end
      if (cnt_q != '1) cnt_d = cnt_q + FW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      cnt_q  <= '0;
      fail_q <= '1;
      seen_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      fail_q <= fail_d;
      seen_q <= seen_d;
    end
  end

  assign fail_round = fail_q;
`endif

  assign val_out = val_q;
  assign ok      = ok_q;
  assign lay_out = lay_q;
  assign v2_out  = v2_q;
  assign ready   = (state_q == IDLE) & ~start;

endmodule
